// File: rtl/hex_msg_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | hex_msg_writer: switch/push-button entry of a hex message into a        |
// | segment-encoded linear buffer read by the marquee scroller.             |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+

module hex_msg_key #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic key_n,
  output logic press_p
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_armed;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Synchronisers reset to "pressed" so that arming needs genuine release evidence.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Until armed, the key must be seen released for a full window; a key held
  // through reset therefore never produces a press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_deb   <= 1'b1;
      r_armed <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_press <= 1'b0;
      if (!r_armed) begin
        if (r_sync2) begin
          if (r_cnt == c_cnt_last) begin
            r_armed <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end else if (r_sync2 != r_deb) begin
        if (r_cnt == c_cnt_last) begin
          r_deb   <= r_sync2;
          r_press <= ~r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press_p = r_press;

endmodule

module hex_msg_writer #(
  parameter int DEPTH      = 16,
  parameter int DEB_CYCLES = 1000000,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  input  logic [3:0]    SW,
  input  logic          KEY_WR,
  input  logic          KEY_DEL,
  input  logic          KEY_CLR,
  input  logic [AW-1:0] RD_ADDR,
  output logic [6:0]    RD_DATA,
  output logic [AW:0]   LEN,
  output logic          FULL,
  output logic          EMPTY,
  output logic          OVF,
  output logic [6:0]    HEX0,
  output logic [6:0]    HEX1
);

  localparam logic [6:0]  c_blank = 7'h7F;
  localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

  function automatic logic [6:0] f_encode(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [2:0]    w_key_n;
  logic [2:0]    w_press;
  logic          w_wr_p;
  logic          w_del_p;
  logic          w_clr_p;
  logic          w_full;
  logic          w_empty;
  logic          w_do_write;
  logic [3:0]    w_len_digit;

  logic [AW:0]   r_len;
  logic          r_ovf;
  logic [6:0]    r_rd_data;
  logic [6:0]    r_hex0;
  logic [6:0]    r_hex1;
  logic [6:0]    r_mem [DEPTH];

  assign w_key_n = {KEY_CLR, KEY_DEL, KEY_WR};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_key
      hex_msg_key #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_key (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .key_n    (w_key_n[i]),
        .press_p  (w_press[i])
      );
    end
  endgenerate

  assign w_wr_p      = w_press[0];
  assign w_del_p     = w_press[1];
  assign w_clr_p     = w_press[2];
  assign w_full      = (r_len == c_depth);
  assign w_empty     = (r_len == '0);
  assign w_do_write  = w_wr_p && !w_del_p && !w_clr_p && !w_full;
  assign w_len_digit = 4'(r_len);

  // Clear dominates; a simultaneous append and delete cancel each other.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (w_clr_p) begin
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (w_wr_p && !w_del_p) begin
      if (w_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_len <= r_len + 1'b1;
      end
    end else if (w_del_p && !w_wr_p && !w_empty) begin
      r_len <= r_len - 1'b1;
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_do_write) begin
      r_mem[r_len[AW-1:0]] <= f_encode(SW);
    end
  end

  // Entries at or beyond LEN read as blank, hiding stale RAM contents.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rd_data <= c_blank;
      r_hex0    <= c_blank;
      r_hex1    <= c_blank;
    end else begin
      r_rd_data <= ({1'b0, RD_ADDR} < r_len) ? r_mem[RD_ADDR] : c_blank;
      r_hex0    <= f_encode(SW);
      r_hex1    <= w_full ? c_blank : f_encode(w_len_digit);
    end
  end

  assign RD_DATA = r_rd_data;
  assign LEN     = r_len;
  assign FULL    = w_full;
  assign EMPTY   = w_empty;
  assign OVF     = r_ovf;
  assign HEX0    = r_hex0;
  assign HEX1    = r_hex1;

endmodule

`default_nettype wire
